mem_io_bridge: RTL and testbench

Memory/IO bridge that sits directly downstream of the CPU in `lab8_top`. It takes the CPU's memory command, address and write data, decodes the address, and completes each access with a `mem_ready` pulse. Targets are:
- a synchronous-read RAM (one-cycle read latency);
- the LEDR output register;
- the slide-switch input, through a 2-flop synchronizer.

Accesses to unmapped addresses return zero and set a sticky error flag.

---
 rtl/lab8_pkg.sv | 26 ++
 rtl/mem_io_bridge_if.sv | 29 ++
 rtl/sync2.sv | 31 +++
 rtl/mem_io_bridge.sv | 100 ++++++++++
 tb/tb_mem_io_bridge.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/lab8_pkg.sv
//------------------------------------------------------------------------------
// Module      : lab8_pkg
// Description : Shared command codes, address map and FSM states for the
//               mem_io_bridge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lab8_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] LEDR_BASE = 9'h100;
  localparam logic [8:0] SW_BASE   = 9'h140;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAM_RD = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_io_bridge_if.sv
//------------------------------------------------------------------------------
// Module      : mem_io_bridge_if
// Description : CPU-side memory command bus (command, address, data, ready).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_io_bridge_if #(
  parameter int DW = 16,
  parameter int AW = 9
);
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          mem_ready;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, mem_ready
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/sync2.sv
//------------------------------------------------------------------------------
// Module      : sync2
// Description : Parameterized-width two-flop synchronizer, cleared by reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync2 #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic [W-1:0] d,
  output logic      [W-1:0] q
);

  logic [W-1:0] r_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      q      <= '0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_io_bridge.sv
//------------------------------------------------------------------------------
// Module      : mem_io_bridge
// Description : Decodes CPU memory commands onto RAM, LEDR and switch targets
//               and completes each access with a one-cycle mem_ready pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_io_bridge
  import lab8_pkg::*;
#(
  parameter int DW  = 16,
  parameter int AW  = 9,
  parameter int RAW = 8
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  mem_io_bridge_if.slave      bus,
  output logic      [RAW-1:0] ram_addr,
  output logic                ram_write,
  output logic      [DW-1:0]  ram_wdata,
  input  wire logic [DW-1:0]  ram_rdata,
  input  wire logic [7:0]     sw_in,
  output logic      [7:0]     ledr,
  output logic                bus_err
);

  state_t        r_state;
  state_t        w_next_state;
  logic [DW-1:0] r_read_data;
  logic [7:0]    w_sw_sync;
  logic          w_is_ram;
  logic          w_is_led;
  logic          w_is_sw;
  logic          w_rd;
  logic          w_wr;

  sync2 #(.W(8)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_in),
    .q     (w_sw_sync)
  );

  assign w_is_ram = ~bus.mem_addr[AW-1];
  assign w_is_led = (bus.mem_addr == LEDR_BASE);
  assign w_is_sw  = (bus.mem_addr == SW_BASE);
  assign w_rd     = (bus.mem_cmd == MREAD);
  assign w_wr     = (bus.mem_cmd == MWRITE);

  assign ram_addr      = bus.mem_addr[RAW-1:0];
  assign ram_wdata     = bus.write_data;
  // Gated with rst_n so no stray strobe escapes while reset is asserted.
  assign ram_write     = (r_state == IDLE) && w_wr && w_is_ram && rst_n;
  assign bus.mem_ready = (r_state == RESP);
  assign bus.read_data = r_read_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_rd && w_is_ram)  w_next_state = RAM_RD;
        else if (w_rd || w_wr) w_next_state = RESP;
      end
      RAM_RD:  w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data <= '0;
      ledr        <= '0;
      bus_err     <= 1'b0;
    end else if (r_state == RAM_RD) begin
      r_read_data <= ram_rdata;
    end else if (r_state == IDLE) begin
      if (w_rd && w_is_led) begin
        r_read_data <= {{(DW-8){1'b0}}, ledr};
      end else if (w_rd && w_is_sw) begin
        r_read_data <= {{(DW-8){1'b0}}, w_sw_sync};
      end else if (w_wr && w_is_led) begin
        ledr <= bus.write_data[7:0];
      end else if ((w_rd || w_wr) && !w_is_ram) begin
        // Unmapped loads and stores (including stores to SW) land here.
        r_read_data <= '0;
        bus_err     <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_io_bridge
// Description : Scoreboard bench for mem_io_bridge with a synchronous RAM model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_io_bridge;
  import lab8_pkg::*;

  typedef struct {
    logic [15:0] data;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [7:0]  sw_in;
  logic [7:0]  ledr;
  logic        bus_err;

  logic [15:0] ram_mem [256];
  exp_t        sb [$];
  int          n_tests;
  int          n_fail;
  int          ready_cnt;
  int          wr_cnt;
  logic [7:0]  last_waddr;

  mem_io_bridge_if #(.DW(16), .AW(9)) bus ();

  mem_io_bridge #(.DW(16), .AW(9), .RAW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .sw_in     (sw_in),
    .ledr      (ledr),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  always @(negedge clk) begin
    if (bus.mem_ready) ready_cnt = ready_cnt + 1;
    if (ram_write) begin
      wr_cnt     = wr_cnt + 1;
      last_waddr = ram_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic [1:0] cmd, input logic [8:0] addr,
                        input logic [15:0] wd, input logic [15:0] exp_rd, input int exp_lat);
    int   cyc;
    int   rc0;
    exp_t e;
    sb.push_back('{data: exp_rd, lat: exp_lat});
    rc0            = ready_cnt;
    bus.mem_cmd    = cmd;
    bus.mem_addr   = addr;
    bus.write_data = wd;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!bus.mem_ready && cyc < 10);
    bus.mem_cmd = MNONE;
    e = sb.pop_front();
    check({tag, ".ready"}, 32'(bus.mem_ready), 32'd1);
    check({tag, ".lat"}, 32'(cyc), 32'(e.lat));
    check({tag, ".rdata"}, 32'(bus.read_data), 32'(e.data));
    @(posedge clk); #1;
    check({tag, ".pulses"}, 32'(ready_cnt - rc0), 32'd1);
  endtask

  initial begin
    int rc0;
    int wc0;
    n_tests = 0; n_fail = 0; ready_cnt = 0; wr_cnt = 0; last_waddr = '0;
    rst_n = 1'b0;
    sw_in = 8'h00;
    bus.mem_cmd = MNONE; bus.mem_addr = '0; bus.write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(bus.mem_ready), 32'd0);
    check("rst.rdata", 32'(bus.read_data), 32'd0);
    check("rst.ledr", 32'(ledr), 32'd0);
    check("rst.err", 32'(bus_err), 32'd0);
    check("rst.ramwr", 32'(ram_write), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Command 11 must be ignored entirely.
    rc0 = ready_cnt; wc0 = wr_cnt;
    bus.mem_cmd = 2'b11; bus.mem_addr = 9'h1FF;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_cmd = MNONE;
    check("cmd11.ready", 32'(ready_cnt - rc0), 32'd0);
    check("cmd11.err", 32'(bus_err), 32'd0);
    check("cmd11.wr", 32'(wr_cnt - wc0), 32'd0);

    wc0 = wr_cnt;
    access("wr005", MWRITE, 9'h005, 16'h97BC, 16'h0000, 1);
    check("wr005.strobes", 32'(wr_cnt - wc0), 32'd1);
    check("wr005.waddr", 32'(last_waddr), 32'h05);
    access("rd005", MREAD, 9'h005, 16'h0000, 16'h97BC, 2);

    wc0 = wr_cnt;
    access("wr0ff", MWRITE, 9'h0FF, 16'h1234, 16'h97BC, 1);
    check("wr0ff.strobes", 32'(wr_cnt - wc0), 32'd1);
    access("rd0ff", MREAD, 9'h0FF, 16'h0000, 16'h1234, 2);

    wc0 = wr_cnt;
    access("wrled", MWRITE, 9'h100, 16'h97BC, 16'h1234, 1);
    check("wrled.ledr", 32'(ledr), 32'hBC);
    check("wrled.noram", 32'(wr_cnt - wc0), 32'd0);
    access("rdled", MREAD, 9'h100, 16'h0000, 16'h00BC, 1);
    check("rdled.err", 32'(bus_err), 32'd0);

    sw_in = 8'hA6;
    repeat (2) @(posedge clk);
    #1;
    access("rdsw", MREAD, 9'h140, 16'h0000, 16'h00A6, 1);
    sw_in = 8'h5B;
    @(posedge clk); #1;
    access("rdsw_old", MREAD, 9'h140, 16'h0000, 16'h00A6, 1);
    access("rdsw_new", MREAD, 9'h140, 16'h0000, 16'h005B, 1);

    access("wrsw", MWRITE, 9'h140, 16'hFFFF, 16'h0000, 1);
    check("wrsw.err", 32'(bus_err), 32'd1);
    check("wrsw.ledr", 32'(ledr), 32'hBC);
    access("rd1ff", MREAD, 9'h1FF, 16'h0000, 16'h0000, 1);
    access("wr101", MWRITE, 9'h101, 16'h00FF, 16'h0000, 1);
    check("wr101.err", 32'(bus_err), 32'd1);
    check("wr101.ledr", 32'(ledr), 32'hBC);
    access("rdled2", MREAD, 9'h100, 16'h0000, 16'h00BC, 1);

    // Reset while the RAM read is in flight.
    rc0 = ready_cnt;
    bus.mem_cmd = MREAD; bus.mem_addr = 9'h005;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.mem_cmd = MNONE;
    #1;
    check("midrst.rdata", 32'(bus.read_data), 32'd0);
    check("midrst.ledr", 32'(ledr), 32'd0);
    check("midrst.err", 32'(bus_err), 32'd0);
    check("midrst.ramwr", 32'(ram_write), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst.noready", 32'(ready_cnt - rc0), 32'd0);
    access("postrst", MREAD, 9'h005, 16'h0000, 16'h97BC, 2);
    check("postrst.err", 32'(bus_err), 32'd0);
    check("sb.empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
